// File: rtl/pll_lock_sequencer_if.sv
// Signals between the PLL lock sequencer and the PLL / downstream reset domain.
// master: the sequencer (samples locked, drives resets and status).
// slave:  the PLL side and the status consumers.
interface pll_lock_sequencer_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  locked,
    output pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up supervisor. Pulses the PLL reset, waits for a synchronized lock
// to hold for LOCK_STABLE_CYCLES, then releases the downstream reset. Lock loss
// restarts the bring-up; too many lock timeouts park the block in FAILED.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_sequencer_if.master pll_if
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                    RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT  = CNT_W'(LOCK_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAILED
  } state_t;

  state_t           r_state, w_state;
  logic             r_lk_meta, r_lk_s;
  logic [CNT_W-1:0] r_pulse, w_pulse;
  logic [CNT_W-1:0] r_tmo, w_tmo;
  logic [CNT_W-1:0] r_stab, w_stab;
  logic [2:0]       r_retry, w_retry;
  logic [7:0]       r_loss, w_loss;
  logic             r_pll_rst, r_sys_rst, r_ready, r_fail;

  logic [CNT_W-1:0] w_tmo_inc, w_stab_inc;
  logic [2:0]       w_retry_inc;
  logic [7:0]       w_loss_inc;
  logic             w_timeout, w_stab_done, w_retry_exhausted;

  assign w_tmo_inc         = r_tmo + CNT_W'(1);
  assign w_stab_inc        = r_stab + CNT_W'(1);
  assign w_timeout         = (w_tmo_inc == TMO_LIMIT);
  // Release once the cycle being counted is the last of the stable window.
  assign w_stab_done       = (w_stab_inc == STAB_LAST);
  assign w_retry_inc       = (r_retry == 3'd7) ? 3'd7 : r_retry + 3'd1;
  assign w_loss_inc        = (r_loss == 8'hFF) ? 8'hFF : r_loss + 8'd1;
  assign w_retry_exhausted = ({29'd0, w_retry_inc} >= MAX_RETRIES);

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_lk_meta <= pll_if.locked;
      r_lk_s    <= r_lk_meta;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RESET_PLL;
      r_pulse   <= '0;
      r_tmo     <= '0;
      r_stab    <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pulse   <= w_pulse;
      r_tmo     <= w_tmo;
      r_stab    <= w_stab;
      r_retry   <= w_retry;
      r_loss    <= w_loss;
      r_pll_rst <= (w_state == S_RESET_PLL) || (w_state == S_FAILED);
      r_sys_rst <= (w_state != S_RUN);
      r_ready   <= (w_state == S_RUN);
      r_fail    <= (w_state == S_FAILED);
    end
  end

  // Next-state and counter update; completing the stable window beats a timeout.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    w_state = r_state;
    w_pulse = r_pulse;
    w_tmo   = r_tmo;
    w_stab  = r_stab;
    w_retry = r_retry;
    w_loss  = r_loss;

    unique case (r_state)
      S_RESET_PLL: begin
        if (r_pulse == PULSE_LAST) begin
          w_state = S_WAIT_LOCK;
          w_pulse = '0;
        end else begin
          w_pulse = r_pulse + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        w_tmo = w_tmo_inc;
        if (r_lk_s && (LOCK_STABLE_CYCLES == 1)) begin
          w_state = S_RUN;
        end else if (w_timeout) begin
          w_retry = w_retry_inc;
          w_state = w_retry_exhausted ? S_FAILED : S_RESET_PLL;
        end else if (r_lk_s) begin
          w_state = S_STABLE;
          w_stab  = '0;
        end
      end
      S_STABLE: begin
        w_tmo = w_tmo_inc;
        if (r_lk_s && w_stab_done) begin
          w_state = S_RUN;
        end else if (w_timeout) begin
          w_retry = w_retry_inc;
          w_state = w_retry_exhausted ? S_FAILED : S_RESET_PLL;
        end else if (!r_lk_s) begin
          w_state = S_WAIT_LOCK;
          w_stab  = '0;
        end else begin
          w_stab = w_stab_inc;
        end
      end
      S_RUN: begin
        if (!r_lk_s) begin
          w_loss  = w_loss_inc;
          w_retry = '0;
          w_state = S_RESET_PLL;
        end
      end
      S_FAILED: begin
        w_state = S_FAILED;
      end
      default: begin
        w_state = S_RESET_PLL;
      end
    endcase

    // A fresh reset pulse always starts with a cleared pulse and timeout count.
    if ((w_state == S_RESET_PLL) && (r_state != S_RESET_PLL)) begin
      w_pulse = '0;
      w_tmo   = '0;
    end
  end

  assign pll_if.pll_rst   = r_pll_rst;
  assign pll_if.sys_rst   = r_sys_rst;
  assign pll_if.ready     = r_ready;
  assign pll_if.fail      = r_fail;
  assign pll_if.retry_cnt = r_retry;
  assign pll_if.loss_cnt  = r_loss;

endmodule
